slc3_button_conditioner: RTL

SLC3_BUTTON_CONDITIONER -- requirements
Module: slc3_button_conditioner

---
 rtl/slc3_io_pkg.sv | 14 +
 rtl/slc3_key_debounce.sv | 105 ++++++++++
 rtl/slc3_button_conditioner.sv | 55 +++++
 3 files changed

// File: rtl/slc3_io_pkg.sv
// Shared types and constants for the SLC-3 pushbutton/switch input conditioning.
package slc3_io_pkg;

  localparam int unsigned CNT_W               = 20;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } btn_state_t;

endpackage

// File: rtl/slc3_key_debounce.sv
// One active-low pushbutton: 2-flop synchronizer, debounce FSM with stability counter,
// one-cycle press strobe and debounced level.
module slc3_key_debounce
  import slc3_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_pulse,
  output logic o_held
);

  localparam logic [CNT_W-1:0] LP_TARGET = CNT_W'(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  btn_state_t       r_state;
  btn_state_t       w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_pulse;
  logic             w_pulse_d;
  logic             w_pressed;

  // Synchronizer idles at 1 so reset looks like a released key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ~r_sync2;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_pulse <= w_pulse_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_pulse_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_pressed) begin
          w_state_d = StPressWait;
          w_cnt_d   = CNT_W'(1);
        end
      end
      StPressWait: begin
        if (!w_pressed) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else if (w_cnt_inc == LP_TARGET) begin
          // Pulse is registered so it lines up with the first HELD cycle.
          w_state_d = StHeld;
          w_cnt_d   = '0;
          w_pulse_d = 1'b1;
        end else begin
          w_cnt_d = w_cnt_inc;
        end
      end
      StHeld: begin
        if (!w_pressed) begin
          w_state_d = StReleaseWait;
          w_cnt_d   = CNT_W'(1);
        end
      end
      StReleaseWait: begin
        if (w_pressed) begin
          w_state_d = StHeld;
          w_cnt_d   = '0;
        end else if (w_cnt_inc == LP_TARGET) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = w_cnt_inc;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  assign o_pulse = r_pulse;
  assign o_held  = (r_state == StHeld) || (r_state == StReleaseWait);

endmodule

// File: rtl/slc3_button_conditioner.sv
// SLC-3 front-panel input conditioning: debounced Run/Continue keys and synchronized
// slide switches.
module slc3_button_conditioner
  import slc3_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run_n,
  input  logic       Continue_n,
  input  logic [9:0] SW_raw,
  output logic       Run_pulse,
  output logic       Continue_pulse,
  output logic       Run_held,
  output logic       Continue_held,
  output logic [9:0] SW_sync
);

  logic [9:0] r_sw_meta;
  logic [9:0] r_sw_sync;

  slc3_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .i_key_n(Run_n),
    .o_pulse(Run_pulse),
    .o_held (Run_held)
  );

  slc3_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_continue (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .i_key_n(Continue_n),
    .o_pulse(Continue_pulse),
    .o_held (Continue_held)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= SW_raw;
      r_sw_sync <= r_sw_meta;
    end
  end

  assign SW_sync = r_sw_sync;

endmodule
